// File: rtl/mesi_isc_tb_ins_gen.sv
// mesi_isc_tb_ins_gen
// Pseudo-random CPU instruction generator for a MESI coherency testbench.
// A 16-bit LFSR selects each instruction (RD/WR/NOP) and its cache line
// address; RD/WR are held until acked, NOP completes on its own. A one-cycle
// NOP gap follows every completed instruction. An ack watchdog ends the run
// if the CPU model stalls.
//
// Ports
//   clk           : clock, rising edge
//   rst           : asynchronous active-low reset
//   start_i       : begin generation (sampled only while idle)
//   tb_ins_ack_i  : CPU model accepted the current RD/WR
//   tb_ins_o      : instruction code (NOP=0, WR=1, RD=2)
//   tb_ins_addr_o : cache line address, 0..9
//   ins_cnt_o     : completed-instruction count (saturating)
//   done_o        : generation finished (sticky until reset)
//   timeout_o     : ack watchdog expired (sticky until reset)
module mesi_isc_tb_ins_gen #(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int unsigned NUM_INS = 1000,
  parameter int unsigned TIMEOUT = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        tb_ins_ack_i,
  output logic [3:0]  tb_ins_o,
  output logic [3:0]  tb_ins_addr_o,
  output logic [15:0] ins_cnt_o,
  output logic        done_o,
  output logic        timeout_o
);

  localparam int unsigned INS_W  = 4;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LFSR_W = 16;
  localparam int unsigned WAIT_W = 32;

  localparam logic [INS_W-1:0] INS_NOP = 4'd0;
  localparam logic [INS_W-1:0] INS_WR  = 4'd1;
  localparam logic [INS_W-1:0] INS_RD  = 4'd2;

  // A zero seed would lock the LFSR, so it falls back to the default seed
  localparam logic [LFSR_W-1:0] LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [CNT_W-1:0]  NUM_INS_C = CNT_W'(NUM_INS);
  localparam logic [WAIT_W-1:0] TIMEOUT_C = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;
  logic [INS_W-1:0]  ins_q, ins_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Instruction code from the two LSBs: RD is twice as likely as WR or NOP
  function automatic logic [INS_W-1:0] dec_op(input logic [LFSR_W-1:0] l);
    logic [INS_W-1:0] op;
    case (l[1:0])
      2'b00, 2'b01: op = INS_RD;
      2'b10:        op = INS_WR;
      default:      op = INS_NOP;
    endcase
    return op;
  endfunction

  // Fold the 4-bit field into the 10 valid cache lines
  function automatic logic [ADDR_W-1:0] dec_addr(input logic [LFSR_W-1:0] l);
    logic [ADDR_W-1:0] a;
    a = l[7:4];
    return (a < 4'd10) ? a : (a - 4'd10);
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[LFSR_W-1:1]};
  endfunction

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cnt_d     = cnt_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    done_d    = done_q;
    ins_d     = INS_NOP;
    addr_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (NUM_INS_C == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            wait_d  = '0;
          end
        end
      end
      ST_ISSUE: begin
        if ((dec_op(lfsr_q) == INS_NOP) || tb_ins_ack_i) begin
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : (cnt_q + CNT_W'(1));
          lfsr_d  = lfsr_step(lfsr_q);
          state_d = ST_GAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          // Abandon the stalled instruction without counting it
          if ((wait_q + WAIT_W'(1)) >= TIMEOUT_C) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_GAP: begin
        wait_d  = '0;
        state_d = (cnt_q == NUM_INS_C) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next-cycle values
    if (state_d == ST_ISSUE) begin
      ins_d  = dec_op(lfsr_d);
      addr_d = dec_addr(lfsr_d);
    end
    done_d = (state_d == ST_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_INIT;
      cnt_q     <= '0;
      wait_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      ins_q     <= INS_NOP;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cnt_q     <= cnt_d;
      wait_q    <= wait_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      ins_q     <= ins_d;
      addr_q    <= addr_d;
    end
  end

  assign tb_ins_o      = ins_q;
  assign tb_ins_addr_o = addr_q;
  assign ins_cnt_o     = cnt_q;
  assign done_o        = done_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_mesi_isc_tb_ins_gen.sv
// Testbench for mesi_isc_tb_ins_gen: directed scenarios plus a long random-ack
// run checked cycle by cycle against a behavioural model of the generator.
module tb_mesi_isc_tb_ins_gen;

  localparam logic [3:0] NOP = 4'd0;
  localparam logic [3:0] WR  = 4'd1;
  localparam logic [3:0] RD  = 4'd2;
  localparam int M_NUM = 1000;
  localparam int M_TO  = 500;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ack = 1'b0;

  logic [3:0]  ins, addr, ins5, addr5, ins0, addr0;
  logic [15:0] cnt, cnt5, cnt0;
  logic        done, tmo, done5, tmo5, done0, tmo0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mesi_isc_tb_ins_gen dut (
    .clk(clk), .rst(rst), .start_i(start), .tb_ins_ack_i(ack),
    .tb_ins_o(ins), .tb_ins_addr_o(addr), .ins_cnt_o(cnt),
    .done_o(done), .timeout_o(tmo)
  );

  mesi_isc_tb_ins_gen #(.SEED(16'h0000), .NUM_INS(5), .TIMEOUT(500)) dut5 (
    .clk(clk), .rst(rst), .start_i(start), .tb_ins_ack_i(ack),
    .tb_ins_o(ins5), .tb_ins_addr_o(addr5), .ins_cnt_o(cnt5),
    .done_o(done5), .timeout_o(tmo5)
  );

  mesi_isc_tb_ins_gen #(.NUM_INS(0)) dut0 (
    .clk(clk), .rst(rst), .start_i(start), .tb_ins_ack_i(ack),
    .tb_ins_o(ins0), .tb_ins_addr_o(addr0), .ins_cnt_o(cnt0),
    .done_o(done0), .timeout_o(tmo0)
  );

  // ---------------- behavioural reference model ----------------
  // Phases: 0 idle, 1 presenting an instruction, 2 gap, 3 finished
  int          m_phase;
  logic [15:0] m_lfsr;
  int          m_cnt;
  int          m_wait;
  bit          m_to;

  function automatic logic [3:0] ref_op(input logic [15:0] l);
    int sel;
    sel = int'(l) % 4;
    if (sel <= 1) return RD;
    if (sel == 2) return WR;
    return NOP;
  endfunction

  function automatic logic [3:0] ref_addr(input logic [15:0] l);
    int a;
    a = (int'(l) / 16) % 16;
    return 4'(a % 10);
  endfunction

  function automatic logic [15:0] ref_next(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return (l >> 1) | (16'(fb) << 15);
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_lfsr  = 16'hACE1;
    m_cnt   = 0;
    m_wait  = 0;
    m_to    = 1'b0;
  endtask

  // Advance the model by one clock given the inputs seen at that edge
  task automatic model_clock(input bit s, input bit a);
    if (m_phase == 0) begin
      if (s) begin m_phase = 1; m_wait = 0; end
    end else if (m_phase == 1) begin
      if (ref_op(m_lfsr) == NOP || a) begin
        m_cnt   = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_lfsr  = ref_next(m_lfsr);
        m_phase = 2;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait >= M_TO) begin m_to = 1'b1; m_phase = 3; end
      end
    end else if (m_phase == 2) begin
      m_phase = (m_cnt == M_NUM) ? 3 : 1;
      m_wait  = 0;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0;
    ack   = 1'b0;
    rst   = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b0;
    tick();
    tests_run += 5;
    if (ins !== NOP)      begin tests_failed++; $display("FAIL reset_ins got=%0d exp=%0d", ins, NOP); end
    if (addr !== 4'd0)    begin tests_failed++; $display("FAIL reset_addr got=%0d exp=0", addr); end
    if (cnt !== 16'd0)    begin tests_failed++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    if (done !== 1'b0)    begin tests_failed++; $display("FAIL reset_done got=%0b exp=0", done); end
    if (tmo !== 1'b0)     begin tests_failed++; $display("FAIL reset_timeout got=%0b exp=0", tmo); end
    // Idle ignores ack
    ack = 1'b1;
    rst = 1'b1;
    tick(); tick();
    tests_run += 2;
    if (ins !== NOP)      begin tests_failed++; $display("FAIL idle_ins got=%0d exp=%0d", ins, NOP); end
    if (cnt !== 16'd0)    begin tests_failed++; $display("FAIL idle_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_first_two();
    do_reset();
    ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run += 3;
    if (ins !== RD)       begin tests_failed++; $display("FAIL first_ins got=%0d exp=%0d", ins, RD); end
    if (addr !== 4'd4)    begin tests_failed++; $display("FAIL first_addr got=%0d exp=4", addr); end
    if (cnt !== 16'd0)    begin tests_failed++; $display("FAIL first_cnt got=%0d exp=0", cnt); end
    tick();
    tests_run += 3;
    if (ins !== NOP)      begin tests_failed++; $display("FAIL gap_ins got=%0d exp=%0d", ins, NOP); end
    if (addr !== 4'd0)    begin tests_failed++; $display("FAIL gap_addr got=%0d exp=0", addr); end
    if (cnt !== 16'd1)    begin tests_failed++; $display("FAIL gap_cnt got=%0d exp=1", cnt); end
    tick();
    tests_run += 2;
    if (ins !== RD)       begin tests_failed++; $display("FAIL second_ins got=%0d exp=%0d", ins, RD); end
    if (addr !== 4'd7)    begin tests_failed++; $display("FAIL second_addr got=%0d exp=7", addr); end
    tick();
    tests_run += 1;
    if (cnt !== 16'd2)    begin tests_failed++; $display("FAIL second_cnt got=%0d exp=2", cnt); end
  endtask

  task automatic test_ack_delay();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests_run += 3;
      if (ins !== RD)    begin tests_failed++; $display("FAIL delay_ins cyc=%0d got=%0d exp=%0d", i, ins, RD); end
      if (addr !== 4'd4) begin tests_failed++; $display("FAIL delay_addr cyc=%0d got=%0d exp=4", i, addr); end
      if (cnt !== 16'd0) begin tests_failed++; $display("FAIL delay_cnt cyc=%0d got=%0d exp=0", i, cnt); end
      if (i == 3) ack = 1'b1;
      tick();
    end
    ack = 1'b0;
    tests_run += 2;
    if (cnt !== 16'd1)    begin tests_failed++; $display("FAIL delay_done_cnt got=%0d exp=1", cnt); end
    if (ins !== NOP)      begin tests_failed++; $display("FAIL delay_gap_ins got=%0d exp=%0d", ins, NOP); end
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (tmo !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    tests_run += 5;
    if (n != 500)         begin tests_failed++; $display("FAIL timeout_cycles got=%0d exp=500", n); end
    if (tmo !== 1'b1)     begin tests_failed++; $display("FAIL timeout_flag got=%0b exp=1", tmo); end
    if (done !== 1'b1)    begin tests_failed++; $display("FAIL timeout_done got=%0b exp=1", done); end
    if (cnt !== 16'd0)    begin tests_failed++; $display("FAIL timeout_cnt got=%0d exp=0", cnt); end
    if (ins !== NOP)      begin tests_failed++; $display("FAIL timeout_ins got=%0d exp=%0d", ins, NOP); end
    // Sticky: a late ack changes nothing
    ack = 1'b1;
    tick(); tick();
    ack = 1'b0;
    tests_run += 2;
    if (tmo !== 1'b1 || done !== 1'b1) begin tests_failed++; $display("FAIL timeout_sticky got=%0b%0b exp=11", tmo, done); end
    if (cnt !== 16'd0)    begin tests_failed++; $display("FAIL timeout_late_ack_cnt got=%0d exp=0", cnt); end
  endtask

  task automatic test_num_ins();
    int n;
    do_reset();
    ack = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run += 5;
    if (ins5 !== RD)      begin tests_failed++; $display("FAIL seed0_ins got=%0d exp=%0d", ins5, RD); end
    if (addr5 !== 4'd4)   begin tests_failed++; $display("FAIL seed0_addr got=%0d exp=4", addr5); end
    if (done0 !== 1'b1)   begin tests_failed++; $display("FAIL num0_done got=%0b exp=1", done0); end
    if (ins0 !== NOP)     begin tests_failed++; $display("FAIL num0_ins got=%0d exp=%0d", ins0, NOP); end
    if (cnt0 !== 16'd0)   begin tests_failed++; $display("FAIL num0_cnt got=%0d exp=0", cnt0); end
    n = 0;
    while (done5 !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tests_run += 3;
    if (n != 10)          begin tests_failed++; $display("FAIL num5_cycles got=%0d exp=10", n); end
    if (cnt5 !== 16'd5)   begin tests_failed++; $display("FAIL num5_cnt got=%0d exp=5", cnt5); end
    if (tmo5 !== 1'b0)    begin tests_failed++; $display("FAIL num5_timeout got=%0b exp=0", tmo5); end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tests_run += 3;
      if (ins5 !== NOP || addr5 !== 4'd0) begin tests_failed++; $display("FAIL num5_after_ins cyc=%0d got=%0d/%0d exp=0/0", i, ins5, addr5); end
      if (done5 !== 1'b1) begin tests_failed++; $display("FAIL num5_after_done cyc=%0d got=%0b exp=1", i, done5); end
      if (cnt5 !== 16'd5) begin tests_failed++; $display("FAIL num5_after_cnt cyc=%0d got=%0d exp=5", i, cnt5); end
      tick();
    end
    ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    tests_run += 1;
    if (ins !== RD)       begin tests_failed++; $display("FAIL mid_pre_ins got=%0d exp=%0d", ins, RD); end
    #2 rst = 1'b0;
    #1;
    tests_run += 4;
    if (ins !== NOP)      begin tests_failed++; $display("FAIL mid_async_ins got=%0d exp=%0d", ins, NOP); end
    if (addr !== 4'd0)    begin tests_failed++; $display("FAIL mid_async_addr got=%0d exp=0", addr); end
    if (cnt !== 16'd0)    begin tests_failed++; $display("FAIL mid_async_cnt got=%0d exp=0", cnt); end
    if (done !== 1'b0)    begin tests_failed++; $display("FAIL mid_async_done got=%0b exp=0", done); end
    tick();
    rst = 1'b1;
    tick();
    tests_run += 1;
    if (ins !== NOP)      begin tests_failed++; $display("FAIL mid_wait_start got=%0d exp=%0d", ins, NOP); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests_run += 2;
    if (ins !== RD)       begin tests_failed++; $display("FAIL mid_restart_ins got=%0d exp=%0d", ins, RD); end
    if (addr !== 4'd4)    begin tests_failed++; $display("FAIL mid_restart_addr got=%0d exp=4", addr); end
  endtask

  task automatic test_random();
    bit seen_nop, seen_rd, seen_wr;
    logic [3:0] e_ins, e_addr;
    int nprint;
    seen_nop = 0; seen_rd = 0; seen_wr = 0;
    nprint = 0;
    start = 1'b0;
    ack = 1'b0;
    rst = 1'b0;
    tick();
    model_reset();
    rst = 1'b1;
    tick();
    for (int i = 0; i < 10000; i++) begin
      start = (i == 0);
      ack = 1'($urandom_range(0, 1));
      model_clock(start, ack);
      tick();
      e_ins  = (m_phase == 1) ? ref_op(m_lfsr) : NOP;
      e_addr = (m_phase == 1) ? ref_addr(m_lfsr) : 4'd0;
      tests_run += 7;
      if (ins !== e_ins) begin
        tests_failed++;
        if (nprint++ < 20) $display("FAIL rand_ins cyc=%0d got=%0d exp=%0d", i, ins, e_ins);
      end
      if (addr !== e_addr) begin
        tests_failed++;
        if (nprint++ < 20) $display("FAIL rand_addr cyc=%0d got=%0d exp=%0d", i, addr, e_addr);
      end
      if (cnt !== 16'(m_cnt)) begin
        tests_failed++;
        if (nprint++ < 20) $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", i, cnt, m_cnt);
      end
      if (done !== (m_phase == 3)) begin
        tests_failed++;
        if (nprint++ < 20) $display("FAIL rand_done cyc=%0d got=%0b exp=%0b", i, done, m_phase == 3);
      end
      if (tmo !== m_to) begin
        tests_failed++;
        if (nprint++ < 20) $display("FAIL rand_timeout cyc=%0d got=%0b exp=%0b", i, tmo, m_to);
      end
      if (addr > 4'd9) begin
        tests_failed++;
        if (nprint++ < 20) $display("FAIL rand_addr_range cyc=%0d got=%0d exp<=9", i, addr);
      end
      if (ins !== NOP && ins !== RD && ins !== WR) begin
        tests_failed++;
        if (nprint++ < 20) $display("FAIL rand_code cyc=%0d got=%0d exp=0/1/2", i, ins);
      end
      if (ins === NOP && m_phase == 1) seen_nop = 1;
      if (ins === RD) seen_rd = 1;
      if (ins === WR) seen_wr = 1;
    end
    start = 1'b0;
    ack = 1'b0;
    tests_run += 4;
    if (!seen_nop)        begin tests_failed++; $display("FAIL rand_seen_nop got=0 exp=1"); end
    if (!seen_rd)         begin tests_failed++; $display("FAIL rand_seen_rd got=0 exp=1"); end
    if (!seen_wr)         begin tests_failed++; $display("FAIL rand_seen_wr got=0 exp=1"); end
    if (cnt !== 16'(M_NUM)) begin tests_failed++; $display("FAIL rand_final_cnt got=%0d exp=%0d", cnt, M_NUM); end
  endtask

  initial begin
    test_reset();
    test_first_two();
    test_ack_delay();
    test_timeout();
    test_num_ins();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
